// File: rtl/k007232_mixer_pkg.sv
// Shared definitions for the K007232 two-channel PCM mixer.
// Holds the sequencer state encoding, the sample midpoint and the
// datapath widths used by the top level and the saturation stage.
package k007232_mixer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CAP,
      MA,
      MB,
      SUM
   } mixState_t;

   localparam int MIDPOINT = 64;
   localparam int SAMPLE_W = 7;
   localparam int VOL_W    = 4;
   localparam int PROD_W   = 11;
   localparam int SUM_W    = 12;
   localparam int OUT_W    = 16;

endpackage

// File: rtl/k007232_mixer_sat.sv
// Shift-and-saturate stage for one output side.
// Ports:
//   sum_i : signed 12-bit side sum
//   sat_o : signed 16-bit result of (sum_i << SHIFT), clamped to the
//           16-bit signed range
// SHIFT is the gain shift amount (0..6).
module k007232_mixer_sat
   import k007232_mixer_pkg::*;
#(
   parameter int SHIFT = 4
)(
   input  logic signed [SUM_W-1:0] sum_i,
   output logic signed [OUT_W-1:0] sat_o
);

   // Wide enough for a 12-bit value shifted by up to 6 with sign headroom.
   localparam int WIDE_W = SUM_W + 7;
   localparam logic signed [WIDE_W-1:0] MAX_V = WIDE_W'(32767);
   localparam logic signed [WIDE_W-1:0] MIN_V = WIDE_W'(-32768);

   logic signed [WIDE_W-1:0] wide;

   // Shift in a widened domain, then clamp anything outside 16-bit signed.
   always_comb begin
      wide = WIDE_W'(sum_i) <<< SHIFT;
      if (wide > MAX_V) begin
         sat_o = 16'sh7FFF;
      end else if (wide < MIN_V) begin
         sat_o = 16'sh8000;
      end else begin
         sat_o = wide[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/k007232_mixer.sv
// K007232 mixer top level: converts two 7-bit offset-binary PCM channels
// into signed 16-bit left/right samples once per DIV i_PCEN pulses.
// Ports:
//   i_EMUCLK, i_RST_n    : clock, async active-low reset
//   i_PCEN               : one-cycle enable pacing the sample divider
//   i_ASD, i_BSD         : channel A/B samples (midpoint 64)
//   i_SLEV_n, i_DB       : volume strobe (latches on rising edge) and byte
//   o_L, o_R             : signed 16-bit outputs, held between samples
//   o_VALID              : one-cycle pulse when o_L/o_R update
//   o_OVF                : sticky flag, a tick arrived while busy
module k007232_mixer
   import k007232_mixer_pkg::*;
#(
   parameter int         DIV        = 128,
   parameter int         GAIN_SHIFT = 4,
   parameter logic [1:0] PAN_A      = 2'b11,
   parameter logic [1:0] PAN_B      = 2'b11
)(
   input  logic                i_EMUCLK,
   input  logic                i_RST_n,
   input  logic                i_PCEN,
   input  logic [SAMPLE_W-1:0] i_ASD,
   input  logic [SAMPLE_W-1:0] i_BSD,
   input  logic                i_SLEV_n,
   input  logic [7:0]          i_DB,
   output logic [OUT_W-1:0]    o_L,
   output logic [OUT_W-1:0]    o_R,
   output logic                o_VALID,
   output logic                o_OVF
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0]         divQ, divD;
   logic                     tick;
   logic                     slevQ;
   logic [VOL_W-1:0]         volAQ, volBQ;
   mixState_t                stateQ;
   logic [SAMPLE_W-1:0]      asdQ, bsdQ;
   logic [VOL_W-1:0]         capVolAQ, capVolBQ;
   logic signed [PROD_W-1:0] paQ;
   logic signed [OUT_W-1:0]  lQ, rQ;
   logic                     validQ, ovfQ;

   logic [SAMPLE_W-1:0]      mulSample;
   logic [VOL_W-1:0]         mulVol;
   logic signed [7:0]        centered;
   logic signed [PROD_W-1:0] product;
   logic signed [SUM_W-1:0]  sumL, sumR;
   logic signed [OUT_W-1:0]  satL, satR;

   // Sample divider: the tick is raised on the pulse that wraps the count.
   always_comb begin
      tick = 1'b0;
      divD = divQ;
      if (i_PCEN) begin
         if (divQ == CNT_W'(DIV - 1)) begin
            divD = '0;
            tick = 1'b1;
         end else begin
            divD = divQ + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         divQ <= '0;
      end else begin
         divQ <= divD;
      end
   end

   // Volume latch loads on a registered low-to-high edge of i_SLEV_n.
   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         slevQ <= 1'b1;
         volAQ <= '0;
         volBQ <= '0;
      end else begin
         slevQ <= i_SLEV_n;
         if (!slevQ && i_SLEV_n) begin
            volAQ <= i_DB[7:4];
            volBQ <= i_DB[3:0];
         end
      end
   end

   // Single shared multiplier: channel A operands in MA, channel B in MB.
   always_comb begin
      if (stateQ == MA) begin
         mulSample = asdQ;
         mulVol    = capVolAQ;
      end else begin
         mulSample = bsdQ;
         mulVol    = capVolBQ;
      end
      centered = $signed({1'b0, mulSample}) - $signed(8'(MIDPOINT));
      product  = PROD_W'(centered) * $signed(PROD_W'({1'b0, mulVol}));
   end

   // Side sums use the registered A product and the live B product in MB.
   always_comb begin
      sumL = (PAN_A[1] ? SUM_W'(paQ) : SUM_W'(0)) + (PAN_B[1] ? SUM_W'(product) : SUM_W'(0));
      sumR = (PAN_A[0] ? SUM_W'(paQ) : SUM_W'(0)) + (PAN_B[0] ? SUM_W'(product) : SUM_W'(0));
   end

   k007232_mixer_sat #(.SHIFT(GAIN_SHIFT)) u_satL (
      .sum_i (sumL),
      .sat_o (satL)
   );

   k007232_mixer_sat #(.SHIFT(GAIN_SHIFT)) u_satR (
      .sum_i (sumR),
      .sat_o (satR)
   );

   // Sequencer. Outputs are loaded on the MB->SUM edge so that o_VALID
   // and the new o_L/o_R are visible during SUM, four cycles after the tick.
   // Ticks arriving outside IDLE are dropped and only set the sticky flag.
   always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         stateQ   <= IDLE;
         asdQ     <= '0;
         bsdQ     <= '0;
         capVolAQ <= '0;
         capVolBQ <= '0;
         paQ      <= '0;
         lQ       <= '0;
         rQ       <= '0;
         validQ   <= 1'b0;
         ovfQ     <= 1'b0;
      end else begin
         validQ <= 1'b0;
         if (tick && stateQ != IDLE) begin
            ovfQ <= 1'b1;
         end
         case (stateQ)
            IDLE: begin
               if (tick) begin
                  stateQ <= CAP;
               end
            end
            CAP: begin
               asdQ     <= i_ASD;
               bsdQ     <= i_BSD;
               capVolAQ <= volAQ;
               capVolBQ <= volBQ;
               stateQ   <= MA;
            end
            MA: begin
               paQ    <= product;
               stateQ <= MB;
            end
            MB: begin
               lQ     <= satL;
               rQ     <= satR;
               validQ <= 1'b1;
               stateQ <= SUM;
            end
            SUM: begin
               stateQ <= IDLE;
            end
            default: begin
               stateQ <= IDLE;
            end
         endcase
      end
   end

   assign o_L     = lQ;
   assign o_R     = rQ;
   assign o_VALID = validQ;
   assign o_OVF   = ovfQ;

endmodule
